// File: rtl/trace_commit_packer.sv
// trace_commit_packer: collects commit records from a 2-wide retire stage,
// drops empty lanes, keeps the rest in order in a small FIFO, and replays
// them two at a time onto registered trace ports for the cosim monitor.
// Each record carries the value of a free-running cycle counter taken when
// the record was accepted.
module trace_commit_packer #(
  parameter int          DEPTH  = 8,
  parameter logic [63:0] HARTID = 64'd0
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_ready,
  input  logic        in_0_valid,
  input  logic [63:0] in_0_iaddr,
  input  logic [31:0] in_0_insn,
  input  logic        in_0_exception,
  input  logic        in_0_interrupt,
  input  logic [63:0] in_0_cause,
  input  logic        in_0_has_wdata,
  input  logic [63:0] in_0_wdata,
  input  logic [2:0]  in_0_priv,
  input  logic        in_1_valid,
  input  logic [63:0] in_1_iaddr,
  input  logic [31:0] in_1_insn,
  input  logic        in_1_exception,
  input  logic        in_1_interrupt,
  input  logic [63:0] in_1_cause,
  input  logic        in_1_has_wdata,
  input  logic [63:0] in_1_wdata,
  input  logic [2:0]  in_1_priv,
  input  logic        out_ready,
  output logic        trace_0_valid,
  output logic [63:0] trace_0_iaddr,
  output logic [31:0] trace_0_insn,
  output logic        trace_0_exception,
  output logic        trace_0_interrupt,
  output logic [63:0] trace_0_cause,
  output logic        trace_0_has_wdata,
  output logic [63:0] trace_0_wdata,
  output logic [2:0]  trace_0_priv,
  output logic        trace_1_valid,
  output logic [63:0] trace_1_iaddr,
  output logic [31:0] trace_1_insn,
  output logic        trace_1_exception,
  output logic        trace_1_interrupt,
  output logic [63:0] trace_1_cause,
  output logic        trace_1_has_wdata,
  output logic [63:0] trace_1_wdata,
  output logic [2:0]  trace_1_priv,
  output logic [63:0] out_cycle,
  output logic [63:0] out_hartid,
  output logic [$clog2(DEPTH):0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef struct packed {
    logic        valid;
    logic [63:0] iaddr;
    logic [31:0] insn;
    logic        exception;
    logic        interrupt;
    logic [63:0] cause;
    logic        has_wdata;
    logic [63:0] wdata;
    logic [2:0]  priv;
  } rec_t;

  typedef struct packed {
    rec_t        rec;
    logic [63:0] cycle;
  } entry_t;

  entry_t          mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW-1:0]   wr_idx1_s;
  logic [AW-1:0]   rd_idx1_s;
  logic [OW-1:0]   occ_r;
  logic [OW-1:0]   occ_next_s;
  logic [63:0]     cycle_r;
  logic            in_ready_r;
  rec_t            rec0_s;
  rec_t            rec1_s;
  rec_t            wr_a_s;
  logic            live0_s;
  logic            live1_s;
  logic [1:0]      push_cnt_s;
  logic [1:0]      pop_cnt_s;
  rec_t            out0_r;
  rec_t            out1_r;
  logic [63:0]     out_cycle_r;

  // Bundle each lane's inputs into a record and decide whether it is live.
  always_comb begin
    rec0_s  = '{valid: in_0_valid, iaddr: in_0_iaddr, insn: in_0_insn,
                exception: in_0_exception, interrupt: in_0_interrupt,
                cause: in_0_cause, has_wdata: in_0_has_wdata,
                wdata: in_0_wdata, priv: in_0_priv};
    rec1_s  = '{valid: in_1_valid, iaddr: in_1_iaddr, insn: in_1_insn,
                exception: in_1_exception, interrupt: in_1_interrupt,
                cause: in_1_cause, has_wdata: in_1_has_wdata,
                wdata: in_1_wdata, priv: in_1_priv};
    live0_s = in_0_valid | in_0_exception | (in_0_cause != 64'd0);
    live1_s = in_1_valid | in_1_exception | (in_1_cause != 64'd0);
  end

  // Push count and compaction: a lone live lane1 takes the first free slot.
  always_comb begin
    push_cnt_s = 2'd0;
    wr_a_s     = rec0_s;
    if (in_ready_r) begin
      push_cnt_s = {1'b0, live0_s} + {1'b0, live1_s};
    end else begin
      push_cnt_s = 2'd0;
    end
    if (live0_s) begin
      wr_a_s = rec0_s;
    end else begin
      wr_a_s = rec1_s;
    end
  end

  // Pop count uses occupancy before this edge's pushes, so there is no bypass.
  always_comb begin
    pop_cnt_s = 2'd0;
    if (!out_ready) begin
      pop_cnt_s = 2'd0;
    end else if (occ_r >= OW'(2)) begin
      pop_cnt_s = 2'd2;
    end else begin
      pop_cnt_s = occ_r[1:0];
    end
    occ_next_s = occ_r + OW'(push_cnt_s) - OW'(pop_cnt_s);
    wr_idx1_s  = wr_ptr_r + AW'(1);
    rd_idx1_s  = rd_ptr_r + AW'(1);
  end

  // Record storage; slots beyond the occupied region are never read.
  always_ff @(posedge clock) begin
    if (reset && (push_cnt_s != 2'd0)) begin
      mem_r[wr_ptr_r] <= '{rec: wr_a_s, cycle: cycle_r};
      if (push_cnt_s == 2'd2) begin
        mem_r[wr_idx1_s] <= '{rec: rec1_s, cycle: cycle_r};
      end
    end
  end

  // Pointers, occupancy, cycle counter and registered ready.
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      occ_r      <= {OW{1'b0}};
      cycle_r    <= 64'd0;
      in_ready_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_r + AW'(push_cnt_s);
      rd_ptr_r   <= rd_ptr_r + AW'(pop_cnt_s);
      occ_r      <= occ_next_s;
      cycle_r    <= cycle_r + 64'd1;
      in_ready_r <= (occ_next_s <= OW'(DEPTH - 2));
    end
  end

  // Registered trace outputs; unfilled lanes are driven to all zeros.
  always_ff @(posedge clock) begin
    if (!reset) begin
      out0_r      <= '0;
      out1_r      <= '0;
      out_cycle_r <= 64'd0;
    end else begin
      if (pop_cnt_s != 2'd0) begin
        out0_r      <= mem_r[rd_ptr_r].rec;
        out_cycle_r <= mem_r[rd_ptr_r].cycle;
      end else begin
        out0_r      <= '0;
        out_cycle_r <= 64'd0;
      end
      if (pop_cnt_s == 2'd2) begin
        out1_r <= mem_r[rd_idx1_s].rec;
      end else begin
        out1_r <= '0;
      end
    end
  end

  assign in_ready          = in_ready_r;
  assign occupancy         = occ_r;
  assign out_cycle         = out_cycle_r;
  assign out_hartid        = HARTID;
  assign trace_0_valid     = out0_r.valid;
  assign trace_0_iaddr     = out0_r.iaddr;
  assign trace_0_insn      = out0_r.insn;
  assign trace_0_exception = out0_r.exception;
  assign trace_0_interrupt = out0_r.interrupt;
  assign trace_0_cause     = out0_r.cause;
  assign trace_0_has_wdata = out0_r.has_wdata;
  assign trace_0_wdata     = out0_r.wdata;
  assign trace_0_priv      = out0_r.priv;
  assign trace_1_valid     = out1_r.valid;
  assign trace_1_iaddr     = out1_r.iaddr;
  assign trace_1_insn      = out1_r.insn;
  assign trace_1_exception = out1_r.exception;
  assign trace_1_interrupt = out1_r.interrupt;
  assign trace_1_cause     = out1_r.cause;
  assign trace_1_has_wdata = out1_r.has_wdata;
  assign trace_1_wdata     = out1_r.wdata;
  assign trace_1_priv      = out1_r.priv;

endmodule

// File: doc/trace_commit_packer.md
Name: trace_commit_packer

Overview:
- Producer-side companion to the Spike cosim monitor. It sits between a core's 2-wide commit stage and the cosim monitor's trace_0/trace_1 input ports.
- Captures per-lane commit records and compacts out empty lanes. Records are buffered in order in a FIFO.
- Drains the FIFO at up to two records per cycle onto registered trace outputs, each tagged with its enqueue cycle.
- Backpressure goes to the core via in_ready. The drain side is throttled by out_ready.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 4.
- HARTID, 0, constant driven on out_hartid.

Ports:
- clock  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- in_ready  output  1  high when at least 2 FIFO entries are free; registered.
- in_N_valid  input  1  lane N retired an instruction (N = 0,1).
- in_N_iaddr  input  64  lane N PC.
- in_N_insn  input  32  lane N instruction bits.
- in_N_exception  input  1  lane N raised an exception.
- in_N_interrupt  input  1  lane N took an interrupt.
- in_N_cause  input  64  lane N trap cause.
- in_N_has_wdata  input  1  lane N wrote a register.
- in_N_wdata  input  64  lane N writeback data.
- in_N_priv  input  3  lane N privilege level.
- out_ready  input  1  consumer accepts records this cycle.
- trace_N_valid, trace_N_iaddr, trace_N_insn, trace_N_exception, trace_N_interrupt, trace_N_cause, trace_N_has_wdata, trace_N_wdata, trace_N_priv  output  same widths as in_N_*  registered output records (N = 0,1).
- out_cycle  output  64  enqueue cycle of the trace_0 record.
- out_hartid  output  64  HARTID.
- occupancy  output  $clog2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Live record: a lane is live when valid OR exception OR (cause != 0). Non-live lanes are discarded.
- Reset (reset == 0 at a posedge):
  - FIFO flushed; occupancy = 0; cycle counter = 0.
  - All trace_* outputs and out_cycle = 0; in_ready = 0.
  - In the first cycle after reset deasserts, in_ready = 1.
  - A reset mid-operation discards all buffered records without emitting them.
- Cycle counter: 64-bit, increments every non-reset cycle, wraps modulo 2^64.
- Enqueue, on a posedge with in_ready == 1:
  - Live lanes are written in order, lane0 before lane1. 0, 1 or 2 entries are written.
  - A lone live lane1 is compacted into the next free slot.
  - Each entry stores its record plus the current counter value.
  - When in_ready == 0, inputs are ignored and not stored; the core must hold them.
- Dequeue, on a posedge with out_ready == 1:
  - Pop min(occupancy, 2) oldest entries, using occupancy before this edge's enqueue.
  - The oldest popped entry goes to trace_0 and out_cycle; the second goes to trace_1.
  - Any unfilled output lane gets all fields = 0.
- When out_ready == 0 or the FIFO is empty, all trace_* fields and out_cycle are set to 0 at the edge. The cosim sees nothing because its valid/exception/cause gate is 0.
- Simultaneous enqueue and dequeue is allowed: occupancy_next = occupancy + pushes − pops.
- in_ready_next = (DEPTH − occupancy_next) >= 2.
- No bypass: minimum latency from input sample edge to visible output is 2 cycles.
  - Edge E: the record is enqueued.
  - Edge E+1: the record is popped and registered.
  - It is visible during the cycle following E+1.
- Read and write pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty are distinguished by occupancy.
- Overflow and underflow are impossible by construction. The bench asserts occupancy <= DEPTH.
- Record order out equals program order in, across lanes and cycles.

Test Plan:
- Reset then single lane0 commit (valid=1, iaddr=0x80000000, insn=0x00000013) at counter 5 -> cycle 7 shows trace_0_valid=1, iaddr=0x80000000, out_cycle=5; trace_1 all 0; occupancy returns to 0.
- Lane0 non-live, lane1 live (iaddr=0x80000004) -> emitted on trace_0, not trace_1.
- Lane0 exception=1, cause=2, valid=0 -> record kept and emitted with trace_0_exception=1, cause=2.
- out_ready=0 while both lanes commit every cycle, DEPTH=8 -> in_ready drops after occupancy reaches 8 (4 cycles). Raising out_ready drains 2 records per cycle in exact program order, and in_ready reasserts once 2 entries are free.
- Alternating out_ready with 3 live records queued -> trace_0/trace_1 pair first, then lone trace_0 with trace_1 all zero.
- Assert reset with 5 entries buffered -> next cycle occupancy=0, outputs 0, and no stale record is ever emitted afterwards.
